// File: rtl/mcyc_ctrl.sv
// mcyc_ctrl: multicycle fetch/decode/execute/writeback controller with mem_ready wait states, timeout and sticky trap
// Ports: clk, reset (async, active-high); op/op_ext/branch_cond/PSR decode inputs; mem_ready handshake;
//   datapath selects/enables (WD_S, ALUA_S, ALUB_S, PC_S, PC_EN, REG_WR_EN, INSTR_EN, ALU_OUT_EN,
//   MEM_REG_EN, MEM_WR_S, MEM_S, SE_SIGN, PSR_EN), mem_req, trap, trap_cause, retired.
// Define MCYC_CTRL_PERF_CNT_EN to build the retired-instruction counter; otherwise retired is 0.
module mcyc_ctrl #(
  parameter int          MEM_TIMEOUT   = 15,
  parameter logic [15:0] ZERO_EXT_MASK = 16'h200E,
  parameter int          CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           op,
  input  logic [3:0]           op_ext,
  input  logic [3:0]           branch_cond,
  input  logic [4:0]           PSR,
  input  logic                 mem_ready,
  output logic [1:0]           WD_S,
  output logic [1:0]           ALUA_S,
  output logic [1:0]           ALUB_S,
  output logic                 PC_S,
  output logic                 PC_EN,
  output logic                 REG_WR_EN,
  output logic                 INSTR_EN,
  output logic                 ALU_OUT_EN,
  output logic                 MEM_REG_EN,
  output logic                 MEM_WR_S,
  output logic                 MEM_S,
  output logic                 SE_SIGN,
  output logic                 PSR_EN,
  output logic                 mem_req,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [CNT_WIDTH-1:0] retired
);
  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_RTYPE = 4'd2, S_ITYPE = 4'd3,
                         S_WRITE = 4'd4, S_LD_MEM = 4'd5, S_LD_WB = 4'd6, S_ST_MEM = 4'd7,
                         S_BR_DISP = 4'd8, S_JUMP = 4'd9, S_LINK_CALC = 4'd10, S_LINK_WR = 4'd11,
                         S_PC_UP = 4'd12, S_TRAP = 4'd13;
  localparam int WW = $clog2(MEM_TIMEOUT + 2);

  logic [3:0]    r_state, w_next;
  logic [WW-1:0] r_wait;
  logic [1:0]    r_cause;
  logic [7:0]    w_base;
  logic          w_cond, w_mem, w_tout, w_retire;

  // Condition codes come in true/inverted pairs: bc[3:1] picks the base term, bc[0] inverts it.
  assign w_base   = {1'b1, ~PSR[4] & ~PSR[3], ~PSR[1] & ~PSR[3], PSR[2], PSR[4], PSR[1], PSR[0], PSR[3]};
  assign w_cond   = w_base[branch_cond[3:1]] ^ branch_cond[0];
  assign w_mem    = r_state == S_FETCH || r_state == S_LD_MEM || r_state == S_ST_MEM;
  // Counter holds the number of low cycles already seen, so ready in cycle MEM_TIMEOUT still wins.
  assign w_tout   = MEM_TIMEOUT != 0 && w_mem && !mem_ready && r_wait == WW'(MEM_TIMEOUT - 1);
  assign w_retire = r_state == S_PC_UP || r_state == S_BR_DISP || r_state == S_JUMP || r_state == S_LINK_WR;
  assign trap_cause = r_cause;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:    case (op)
                     4'b0000: w_next = S_RTYPE;
                     4'b1100: w_next = w_cond ? S_BR_DISP : S_PC_UP;
                     4'b0100: case (op_ext)
                                4'b0000: w_next = S_LD_MEM;
                                4'b0100: w_next = S_ST_MEM;
                                4'b1000: w_next = S_LINK_CALC;
                                4'b1100: w_next = w_cond ? S_JUMP : S_PC_UP;
                                default: w_next = S_TRAP;
                              endcase
                     default: w_next = S_ITYPE;
                   endcase
      S_RTYPE:     w_next = op_ext == 4'b1011 ? S_PC_UP : S_WRITE;
      S_ITYPE:     w_next = op == 4'b1011 ? S_PC_UP : S_WRITE;
      S_WRITE:     w_next = S_PC_UP;
      S_LD_MEM:    w_next = mem_ready ? S_LD_WB : S_LD_MEM;
      S_LD_WB:     w_next = S_PC_UP;
      S_ST_MEM:    w_next = mem_ready ? S_PC_UP : S_ST_MEM;
      S_LINK_CALC: w_next = S_LINK_WR;
      S_TRAP:      w_next = S_TRAP;
      default:     w_next = S_FETCH;
    endcase
    if (w_tout) w_next = S_TRAP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
      r_cause <= 2'b00;
    end else begin
      r_state <= w_next;
      // Leaving or entering a memory state always happens with the counter at zero.
      r_wait  <= (w_mem && !mem_ready) ? r_wait + 1'b1 : '0;
      if (w_next == S_TRAP && r_state != S_TRAP) r_cause <= w_tout ? 2'b01 : 2'b10;
    end
  end

  // Outputs are gated by reset so FETCH's memory request never escapes while reset is held.
  always_comb begin
    {WD_S, ALUA_S, ALUB_S} = '0;
    {PC_S, PC_EN, REG_WR_EN, INSTR_EN, ALU_OUT_EN, MEM_REG_EN, MEM_WR_S, MEM_S, PSR_EN, mem_req, trap} = '0;
    SE_SIGN = 1'b1;
    if (!reset) begin
      case (r_state)
        S_FETCH:     begin MEM_S = 1'b1; mem_req = 1'b1; INSTR_EN = mem_ready; end
        S_RTYPE:     begin ALU_OUT_EN = 1'b1; PSR_EN = 1'b1; end
        S_ITYPE:     begin ALUA_S = 2'b01; ALU_OUT_EN = 1'b1; PSR_EN = 1'b1; SE_SIGN = ~ZERO_EXT_MASK[op]; end
        S_WRITE:     begin WD_S = 2'b11; REG_WR_EN = 1'b1; end
        S_LD_MEM:    begin mem_req = 1'b1; MEM_REG_EN = mem_ready; end
        S_LD_WB:     begin WD_S = 2'b10; REG_WR_EN = 1'b1; end
        S_ST_MEM:    begin mem_req = 1'b1; MEM_WR_S = 1'b1; end
        S_BR_DISP:   begin ALUA_S = 2'b01; ALUB_S = 2'b01; PC_S = 1'b1; PC_EN = 1'b1; end
        S_JUMP:      PC_EN = 1'b1;
        S_LINK_CALC: begin ALUA_S = 2'b01; ALU_OUT_EN = 1'b1; end
        S_LINK_WR:   begin WD_S = 2'b11; REG_WR_EN = 1'b1; PC_EN = 1'b1; end
        S_PC_UP:     begin ALUA_S = 2'b01; ALUB_S = 2'b10; PC_S = 1'b1; PC_EN = 1'b1; end
        S_TRAP:      trap = 1'b1;
        default:     ;
      endcase
    end
  end

`ifdef MCYC_CTRL_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_retired;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + 1'b1;
  end
  assign retired = r_retired;
`else
  logic w_unused;
  assign w_unused = w_retire;
  assign retired  = '0;
`endif
endmodule

// File: tb/tb_mcyc_ctrl.sv
// tb_mcyc_ctrl: randomized instruction-level check of mcyc_ctrl against per-instruction expected output sequences
module tb_mcyc_ctrl;
  logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b0;
  logic [3:0] op = '0, op_ext = '0, branch_cond = '0;
  logic [4:0] PSR = '0;
  logic [1:0] WD_S, ALUA_S, ALUB_S, trap_cause;
  logic PC_S, PC_EN, REG_WR_EN, INSTR_EN, ALU_OUT_EN, MEM_REG_EN, MEM_WR_S, MEM_S, SE_SIGN, PSR_EN, mem_req, trap;
  logic [31:0] retired;
  int n_vec = 0, n_err = 0, exp_ret = 0;

  // Output word: {WD_S, ALUA_S, ALUB_S, PC_S, PC_EN, REG_WR_EN, INSTR_EN, ALU_OUT_EN, MEM_REG_EN,
  //               MEM_WR_S, MEM_S, SE_SIGN, PSR_EN, mem_req, trap}
  localparam logic [17:0] WD3 = 18'h30000, WD2 = 18'h20000, AA1 = 18'h04000, AB1 = 18'h01000,
                          AB2 = 18'h02000, PCS = 18'h00800, PCE = 18'h00400, RWE = 18'h00200,
                          IEN = 18'h00100, AOE = 18'h00080, MRE = 18'h00040, MWS = 18'h00020,
                          MS  = 18'h00010, SE  = 18'h00008, PSE = 18'h00004, MRQ = 18'h00002,
                          TRP = 18'h00001;
  localparam logic [17:0] FET = MS | MRQ | SE, PCUP = AA1 | AB2 | PCS | PCE | SE,
                          BR = AA1 | AB1 | PCS | PCE | SE, WR = WD3 | RWE | SE;
  localparam logic [15:0] ZMASK = 16'h200E;

  mcyc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .op_ext(op_ext), .branch_cond(branch_cond), .PSR(PSR),
    .mem_ready(mem_ready), .WD_S(WD_S), .ALUA_S(ALUA_S), .ALUB_S(ALUB_S), .PC_S(PC_S), .PC_EN(PC_EN),
    .REG_WR_EN(REG_WR_EN), .INSTR_EN(INSTR_EN), .ALU_OUT_EN(ALU_OUT_EN), .MEM_REG_EN(MEM_REG_EN),
    .MEM_WR_S(MEM_WR_S), .MEM_S(MEM_S), .SE_SIGN(SE_SIGN), .PSR_EN(PSR_EN), .mem_req(mem_req),
    .trap(trap), .trap_cause(trap_cause), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] obs();
    return {WD_S, ALUA_S, ALUB_S, PC_S, PC_EN, REG_WR_EN, INSTR_EN, ALU_OUT_EN, MEM_REG_EN,
            MEM_WR_S, MEM_S, SE_SIGN, PSR_EN, mem_req, trap};
  endfunction

  function automatic int ret_exp();
`ifdef MCYC_CTRL_PERF_CNT_EN
    return exp_ret;
`else
    return 0;
`endif
  endfunction

  function automatic bit cond(input logic [3:0] bc, input logic [4:0] p);
    bit n = p[4], z = p[3], f = p[2], l = p[1], c = p[0];
    case (bc)
      4'd0: return z;          4'd1: return !z;
      4'd2: return c;          4'd3: return !c;
      4'd4: return l;          4'd5: return !l;
      4'd6: return n;          4'd7: return !n;
      4'd8: return f;          4'd9: return !f;
      4'd10: return !l && !z;  4'd11: return l || z;
      4'd12: return !n && !z;  4'd13: return n || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    chk("rst_out", 32'(obs()), 32'(SE));
    chk("rst_cause", 32'(trap_cause), 0);
    chk("rst_retired", retired, 0);
    step();
    reset = 1'b0;
    exp_ret = 0;
  endtask

  // Builds the expected per-cycle outputs of one instruction (fw fetch waits, mw memory waits),
  // then plays it; ready code 2 means mem_ready is don't-care and gets randomized.
  task automatic run_instr(input logic [3:0] o, input logic [3:0] e, input logic [3:0] b,
                           input logic [4:0] p, input int fw, input int mw, output bit trapped);
    logic [17:0] qw[$];
    int qr[$];
    op = o; op_ext = e; branch_cond = b; PSR = p;
    trapped = 1'b0;
    for (int i = 0; i < fw; i++) begin qw.push_back(FET); qr.push_back(0); end
    qw.push_back(FET | IEN); qr.push_back(1);
    qw.push_back(SE); qr.push_back(2);
    if (o == 4'd0) begin
      qw.push_back(AOE | PSE | SE); qr.push_back(2);
      if (e != 4'd11) begin qw.push_back(WR); qr.push_back(2); end
      qw.push_back(PCUP); qr.push_back(2);
    end else if (o == 4'd12) begin
      qw.push_back(cond(b, p) ? BR : PCUP); qr.push_back(2);
    end else if (o == 4'd4) begin
      case (e)
        4'd0: begin
          for (int i = 0; i < mw; i++) begin qw.push_back(MRQ | SE); qr.push_back(0); end
          qw.push_back(MRQ | MRE | SE); qr.push_back(1);
          qw.push_back(WD2 | RWE | SE); qr.push_back(2);
          qw.push_back(PCUP); qr.push_back(2);
        end
        4'd4: begin
          for (int i = 0; i <= mw; i++) begin qw.push_back(MRQ | MWS | SE); qr.push_back(i == mw); end
          qw.push_back(PCUP); qr.push_back(2);
        end
        4'd8: begin
          qw.push_back(AA1 | AOE | SE); qr.push_back(2);
          qw.push_back(WR | PCE); qr.push_back(2);
        end
        4'd12: begin
          qw.push_back(cond(b, p) ? (PCE | SE) : PCUP); qr.push_back(2);
        end
        default: begin
          trapped = 1'b1;
          for (int i = 0; i < 3; i++) begin qw.push_back(TRP | SE); qr.push_back(2); end
        end
      endcase
    end else begin
      qw.push_back(AA1 | AOE | PSE | (ZMASK[o] ? 18'h0 : SE)); qr.push_back(2);
      if (o != 4'd11) begin qw.push_back(WR); qr.push_back(2); end
      qw.push_back(PCUP); qr.push_back(2);
    end
    foreach (qw[i]) begin
      mem_ready = qr[i] == 2 ? 1'($urandom_range(0, 1)) : qr[i][0];
      #4;
      chk($sformatf("op%0h_ext%0h_cyc%0d", o, e, i), 32'(obs()), 32'(qw[i]));
      step();
    end
    if (trapped) chk("illegal_cause", 32'(trap_cause), 2);
    else begin
      exp_ret++;
      chk("retired", retired, ret_exp());
    end
  endtask

  initial begin
    bit t;
    do_reset();
    run_instr(4'd0, 4'd5, 4'd0, 5'd0, 0, 0, t);          // ADD
    run_instr(4'd12, 4'd0, 4'd0, 5'b01000, 0, 0, t);     // BEQ taken
    run_instr(4'd12, 4'd0, 4'd0, 5'b00000, 0, 0, t);     // BEQ not taken
    run_instr(4'd4, 4'd0, 4'd0, 5'd0, 0, 3, t);          // load, 3 waits
    run_instr(4'd2, 4'd0, 4'd0, 5'd0, 0, 0, t);          // ORI
    run_instr(4'd5, 4'd0, 4'd0, 5'd0, 0, 0, t);          // ADDI
    run_instr(4'd4, 4'd0, 4'd0, 5'd0, 14, 14, t);        // ready in the last allowed cycle
    run_instr(4'd4, 4'd4, 4'd0, 5'd0, 14, 14, t);
    run_instr(4'd4, 4'd2, 4'd0, 5'd0, 0, 0, t);          // illegal op_ext
    do_reset();
    // Fetch timeout: 15 low cycles, TRAP after the 15th edge, sticky until reset.
    op = 4'd0;
    for (int i = 0; i < 15; i++) begin
      mem_ready = 1'b0;
      #4;
      chk($sformatf("tout_wait%0d", i), 32'(obs()), 32'(FET));
      step();
    end
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #4;
      chk("tout_trap", 32'(obs()), 32'(TRP | SE));
      chk("tout_cause", 32'(trap_cause), 1);
      step();
    end
    do_reset();
    // Asynchronous reset in a store wait state.
    op = 4'd4; op_ext = 4'd4; mem_ready = 1'b1;
    #4 chk("st_fetch", 32'(obs()), 32'(FET | IEN));
    step();
    mem_ready = 1'b0;
    #4 chk("st_decode", 32'(obs()), 32'(SE));
    step();
    #4 chk("st_wait", 32'(obs()), 32'(MRQ | MWS | SE));
    #2 reset = 1'b1;
    #1 chk("st_async_rst", 32'(obs()), 32'(SE));
    do_reset();
    for (int k = 0; k < 200; k++) begin
      logic [3:0] o, e;
      int fw;
      o = 4'($urandom_range(0, 15));
      e = 4'($urandom_range(0, 15));
      if (o == 4'd4 && $urandom_range(0, 15) != 0) e = 4'($urandom_range(0, 3) * 4);
      fw = $urandom_range(0, 9) == 0 ? 14 : $urandom_range(0, 3);
      run_instr(o, e, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), fw, $urandom_range(0, 3), t);
      if (t) do_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mcyc_ctrl.md
# mcyc_ctrl

Parametrised multicycle controller FSM: next generation of the core's control unit. Sequences fetch/decode/execute/writeback for the 16-bit ISA and drives every datapath select and enable. Adds a `mem_ready` handshake with wait states, a memory timeout, a sticky trap state replacing the dead-end state, and a configurable zero-extend opcode mask. An optional retired-instruction counter sits alongside the core FSM.

## Interface
- `MEM_TIMEOUT`, default 15: consecutive `mem_ready`-low cycles in a memory state before trap; 0 disables the timeout.
- `ZERO_EXT_MASK`, default 16'h200E: bit *n* set means I-type op *n* is zero-extended (ANDI, ORI, XORI, MOVI).
- `CNT_WIDTH`, default 32: width of `retired`.
- `clk` in 1: the one clock.
- `reset` in 1: asynchronous, active-high.
- `op` in 4: instruction [15:12].
- `op_ext` in 4: instruction [7:4].
- `branch_cond` in 4: condition field.
- `PSR` in 5: {N,Z,F,L,C} = [4:0].
- `mem_ready` in 1: memory completes the current request this cycle.
- `WD_S`, `ALUA_S`, `ALUB_S` out 2 each: write-data, ALU A and ALU B selects.
- `PC_S`, `PC_EN`, `REG_WR_EN`, `INSTR_EN`, `ALU_OUT_EN`, `MEM_REG_EN`, `MEM_WR_S`, `MEM_S`, `SE_SIGN`, `PSR_EN` out 1 each.
- `mem_req` out 1: memory request.
- `trap` out 1: FSM is in TRAP.
- `trap_cause` out 2: 01 timeout, 10 illegal op_ext, 00 none.
- `retired` out CNT_WIDTH: retired-instruction count.

## Operation
- Outputs are Moore/combinational from state. Defaults: all 0, except `SE_SIGN`=1.
- While `reset`=1: state is FETCH, counters are 0, `trap_cause`=00, and every output is forced to its default, including `mem_req`=0 and `MEM_S`=0.
- FETCH: `MEM_S`, `mem_req`; `INSTR_EN`=`mem_ready`.
  - `mem_ready`=1 -> DECODE; otherwise hold.
- DECODE, no outputs; next state by `op`:
  - 0000 -> RTYPE_EX.
  - 1100 -> PC_UP if the condition is false, else BR_DISP.
  - 0100 -> by `op_ext`:
    - 0000 -> LD_MEM.
    - 0100 -> ST_MEM.
    - 1000 -> LINK_CALC.
    - 1100 -> JUMP if the condition is true, else PC_UP.
    - any other value -> TRAP, cause 10.
  - All other ops -> ITYPE_EX.
- RTYPE_EX: `ALU_OUT_EN`, `PSR_EN`.
  - `op_ext`=1011 (CMP) -> PC_UP; otherwise -> WRITE.
- ITYPE_EX: `ALUA_S`=01, `ALU_OUT_EN`, `PSR_EN`, `SE_SIGN`=~`ZERO_EXT_MASK`[op].
  - `op`=1011 (CMPI) -> PC_UP; otherwise -> WRITE.
- WRITE: `WD_S`=11, `REG_WR_EN`. -> PC_UP.
- LD_MEM: `mem_req`; `MEM_REG_EN`=`mem_ready`. Ready -> LD_WB.
- LD_WB: `WD_S`=10, `REG_WR_EN`. -> PC_UP.
- ST_MEM: `mem_req`, `MEM_WR_S`. Ready -> PC_UP.
- BR_DISP: `ALUA_S`=01, `ALUB_S`=01, `PC_S`, `PC_EN`. -> FETCH.
- JUMP: `PC_EN`. -> FETCH.
- LINK_CALC: `ALUA_S`=01, `ALU_OUT_EN`. -> LINK_WR.
- LINK_WR: `WD_S`=11, `REG_WR_EN`, `PC_EN`. -> FETCH.
- PC_UP: `ALUA_S`=01, `ALUB_S`=10, `PC_S`, `PC_EN`. -> FETCH.
- TRAP: `trap`=1. Sticky until `reset`.
- Conditions, by `branch_cond` 0000-1111:
  - 0000 Z; 0001 !Z; 0010 C; 0011 !C.
  - 0100 L; 0101 !L; 0110 N; 0111 !N.
  - 1000 F; 1001 !F; 1010 !L&!Z; 1011 L|Z.
  - 1100 !N&!Z; 1101 N|Z; 1110 always; 1111 never.
- Wait counter: cleared on entry to FETCH, LD_MEM and ST_MEM; increments each cycle with `mem_ready`=0.
- Timeout: after MEM_TIMEOUT consecutive low cycles, the next edge goes to TRAP with cause 01.

## Timing
- Zero-wait latencies, FETCH to next FETCH:
  - R/I ALU op: 5 cycles.
  - CMP/CMPI: 4.
  - Load: 5. Store: 4.
  - Bcond taken or not, Jcond taken or not: 3.
  - JAL: 4.
- Each memory wait cycle adds 1 cycle.
- `mem_ready` is sampled only in FETCH, LD_MEM and ST_MEM; it is ignored elsewhere.
- Ready arriving in cycle MEM_TIMEOUT (the counter is at MEM_TIMEOUT-1) completes normally, with no trap.
- Asynchronous `reset` mid-instruction aborts immediately; fetch restarts on the first edge after deassertion.
- `retired` increments by 1 on each edge leaving PC_UP, BR_DISP, JUMP or LINK_WR, and wraps modulo 2^CNT_WIDTH.

## Configuration
- `MCYC_CTRL_PERF_CNT_EN` defined: the `retired` counter is present as above.
- Undefined: no counter register; `retired` is tied to 0.
- FSM behaviour is identical either way.

## Test plan
- Reset, then R-type ADD (op 0000, op_ext 0101) with `mem_ready`=1:
  - state sequence FETCH, DECODE, RTYPE_EX, WRITE, PC_UP.
  - `REG_WR_EN` high for 1 cycle with `WD_S`=11.
  - `retired`=1.
- Bcond EQ with Z=1: DECODE -> BR_DISP (`ALUB_S`=01).
- Bcond EQ with Z=0: DECODE -> PC_UP (`ALUB_S`=10).
- Load with `mem_ready` low for 3 cycles:
  - LD_MEM held 4 cycles; `MEM_REG_EN` pulses only in the 4th.
  - LD_WB gives `WD_S`=10 and `REG_WR_EN`=1.
- Fetch with `mem_ready` stuck at 0 and MEM_TIMEOUT=15:
  - TRAP on the 15th edge; `trap`=1, `trap_cause`=01.
  - Stays there until `reset`, which returns to FETCH with `trap_cause`=00.
- Illegal op_ext (op 0100, op_ext 0010): DECODE -> TRAP, cause 10.
- ORI (op 0010): `SE_SIGN`=0 in ITYPE_EX. ADDI (op 0101): `SE_SIGN`=1.
- Assert `reset` during ST_MEM wait: `MEM_WR_S` and `mem_req` drop to 0 immediately, without waiting for a clock edge.
